// File: rtl/dmem_arbiter.sv
// Single-port DataMemory arbiter: CPU fixed priority, debug wins after MAX_WAIT denied cycles.
// Grants are combinational; read data returns one cycle after grant; no queueing, requesters hold until granted.
module dmem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0]  wait_cnt;
    logic              dbg_win;
    logic              cpu_win;
    logic              cpu_pend;
    logic              dbg_pend;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] dbg_hold;

    always_comb begin
        dbg_win = 1'b0;
        cpu_win = 1'b0;
        if (!reset) begin
            dbg_win = dbg_req && (!cpu_req || wait_cnt == CNT_W'(MAX_WAIT));
            cpu_win = cpu_req && !dbg_win;
        end
    end

    assign cpu_gnt = cpu_win;
    assign dbg_gnt = dbg_win;

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        if (dbg_win) begin
            mem_address = dbg_addr;
            mem_data    = dbg_wdata;
            mem_wren    = dbg_we;
        end else if (cpu_win) begin
            mem_address = cpu_addr;
            mem_data    = cpu_wdata;
            mem_wren    = cpu_we;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
            cpu_pend <= 1'b0;
            dbg_pend <= 1'b0;
            cpu_hold <= '0;
            dbg_hold <= '0;
        end else begin
            if (dbg_req && !dbg_win) begin
                if (wait_cnt != CNT_W'(MAX_WAIT))
                    wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            cpu_pend <= cpu_win && !cpu_we;
            dbg_pend <= dbg_win && !dbg_we;
            if (cpu_rvalid)
                cpu_hold <= mem_q;
            if (dbg_rvalid)
                dbg_hold <= mem_q;
        end
    end

    // A return that lands while reset is high belongs to an aborted access and is dropped.
    assign cpu_rvalid = cpu_pend && !reset;
    assign dbg_rvalid = dbg_pend && !reset;
    assign cpu_rdata  = cpu_rvalid ? mem_q : cpu_hold;
    assign dbg_rdata  = dbg_rvalid ? mem_q : dbg_hold;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: synchronous memory model plus per-owner scoreboard of expected read returns.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [15:0] dbg_addr, dbg_wdata, dbg_rdata;
    logic [15:0] mem_address, mem_data, mem_q;
    logic        mem_wren;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          stamp;
        logic [15:0] dat;
    } ret_t;

    ret_t        cq[$];
    ret_t        dq[$];
    logic [15:0] mem     [0:255];
    logic [15:0] ref_mem [0:255];

    always #5 clock = ~clock;

    dmem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    // Synchronous single-port memory: read data one cycle after the address.
    always @(posedge clock) begin
        if (mem_wren)
            mem[mem_address[7:0]] <= mem_data;
        mem_q <= mem[mem_address[7:0]];
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Return checker: a read granted in cycle N must come back in N+1 only.
    always @(negedge clock) begin
        if (reset) begin
            check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
            check("rst_dbg_rvalid", dbg_rvalid, 1'b0);
            cq.delete();
            dq.delete();
        end else begin
            if (cq.size() > 0 && cq[0].stamp == cyc - 1) begin
                check("cpu_rvalid", cpu_rvalid, 1'b1);
                check("cpu_rdata", cpu_rdata, cq[0].dat);
                void'(cq.pop_front());
            end else begin
                check("cpu_rvalid_idle", cpu_rvalid, 1'b0);
            end
            if (dq.size() > 0 && dq[0].stamp == cyc - 1) begin
                check("dbg_rvalid", dbg_rvalid, 1'b1);
                check("dbg_rdata", dbg_rdata, dq[0].dat);
                void'(dq.pop_front());
            end else begin
                check("dbg_rvalid_idle", dbg_rvalid, 1'b0);
            end
            if (cpu_gnt && !cpu_we)
                cq.push_back('{cyc, ref_mem[cpu_addr[7:0]]});
            if (dbg_gnt && !dbg_we)
                dq.push_back('{cyc, ref_mem[dbg_addr[7:0]]});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic dbg_write(input logic [15:0] a, input logic [15:0] d);
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
        @(negedge clock);
        check("wr_gnt", dbg_gnt, 1'b1);
        check("wr_wren", mem_wren, 1'b1);
        check("wr_addr", mem_address, a);
        check("wr_data", mem_data, d);
        ref_mem[a[7:0]] = d;
        step();
        dbg_req = 1'b0; dbg_we = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] a);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        @(negedge clock);
        check("crd_gnt", cpu_gnt, 1'b1);
        check("crd_dgnt", dbg_gnt, 1'b0);
        check("crd_addr", mem_address, a);
        check("crd_wren", mem_wren, 1'b0);
        step();
        cpu_req = 1'b0;
    endtask

    task automatic dbg_read(input logic [15:0] a);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = a;
        @(negedge clock);
        check("drd_gnt", dbg_gnt, 1'b1);
        check("drd_addr", mem_address, a);
        step();
        dbg_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0; dbg_wdata = 16'h0;
        // Requests held during reset must not be granted.
        @(negedge clock);
        check("rst_cpu_gnt", cpu_gnt, 1'b0);
        check("rst_dbg_gnt", dbg_gnt, 1'b0);
        check("rst_wren", mem_wren, 1'b0);
        step();
        reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        @(negedge clock);
        check("idle_addr", mem_address, 16'h0);
        check("idle_rdata_cpu", cpu_rdata, 16'h0);
        check("idle_rdata_dbg", dbg_rdata, 16'h0);
        step();

        // Preload through the debug port.
        dbg_write(16'h0010, 16'h1234);
        dbg_write(16'h0001, 16'h0A0A);
        dbg_write(16'h0002, 16'h0B0B);
        step();

        // Simple CPU load; value held afterwards.
        cpu_read(16'h0010);
        step();
        step();
        @(negedge clock);
        check("cpu_hold", cpu_rdata, 16'h1234);
        step();

        // Contention: debug wins every fifth cycle.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0002;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check($sformatf("arb_cpu_%0d", i), cpu_gnt, (i != 4 && i != 9));
            check($sformatf("arb_dbg_%0d", i), dbg_gnt, (i == 4 || i == 9));
            step();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();

        // Debug write then CPU read of same address.
        dbg_write(16'h0020, 16'hBEEF);
        cpu_read(16'h0020);
        @(negedge clock);
        check("post_wr_wren", mem_wren, 1'b0);
        step();
        step();

        // Back-to-back reads from different owners.
        cpu_read(16'h0001);
        dbg_read(16'h0002);
        step();
        step();

        // Withdrawn debug request restarts the wait count.
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("wd_pre_%0d", i), dbg_gnt, 1'b0);
            step();
        end
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("wd_post_%0d", i), dbg_gnt, (i == 4));
            check($sformatf("wd_cpu_%0d", i), cpu_gnt, (i != 4));
            step();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        step();

        // Reset right after a CPU read grant discards the return.
        cpu_read(16'h0002);
        reset = 1'b1; cpu_req = 1'b1;
        @(negedge clock);
        check("rst2_cpu_gnt", cpu_gnt, 1'b0);
        check("rst2_wren", mem_wren, 1'b0);
        step();
        reset = 1'b0; cpu_req = 1'b0;
        @(negedge clock);
        check("rst2_cpu_rdata", cpu_rdata, 16'h0);
        check("rst2_dbg_rdata", dbg_rdata, 16'h0);
        check("rst2_gnt", {cpu_gnt, dbg_gnt}, 2'b00);
        check("rst2_mem", {mem_address, mem_data, 15'h0, mem_wren}, 32'h0);
        step();

        // Wait count cleared by reset: CPU keeps four cycles before debug wins.
        cpu_req = 1'b1; cpu_addr = 16'h0010;
        dbg_req = 1'b1; dbg_addr = 16'h0002;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check($sformatf("rst_wc_%0d", i), dbg_gnt, (i == 4));
            step();
        end
        cpu_req = 1'b0; dbg_req = 1'b0;
        step();
        step();

        check("cpu_q_empty", cq.size(), 0);
        check("dbg_q_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
